// File: rtl/merlin_ibus_rsp32.sv
// merlin_ibus_rsp32 -- instruction-bus fetch responder.
// Accepts 32-bit fetch requests and reads a fixed-latency word memory.
// Responses are returned in order through a credit-guarded FIFO.
// Optional: define MERLIN_IBUS_RSP_HPL_CHECK_EN to reject requests whose
// privilege level is below C_MIN_HPL. Without it, ireqhpl_i is ignored.
module merlin_ibus_rsp32 #(
  parameter int unsigned C_MEM_LATENCY = 1,
  parameter int unsigned C_RSP_DEPTH_X = 2,
  parameter int unsigned C_MEM_ADDR_W  = 12,
  parameter logic [31:0] C_BASE_ADDR   = 32'b0,
  parameter logic [1:0]  C_MIN_HPL     = 2'b00
) (
  input  logic                    clk_i,
  input  logic                    resetb_i,
  input  logic                    clk_en_i,
  output logic                    ireqready_o,
  input  logic                    ireqvalid_i,
  input  logic [1:0]              ireqhpl_i,
  input  logic [31:0]             ireqaddr_i,
  input  logic                    irspready_i,
  output logic                    irspvalid_o,
  output logic                    irsprerr_o,
  output logic [31:0]             irspdata_o,
  output logic                    mem_en_o,
  output logic                    mem_rd_o,
  output logic [C_MEM_ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]             mem_rdata_i
);

  localparam int unsigned LP_DEPTH = 1 << C_RSP_DEPTH_X;
  localparam int unsigned LP_CW    = C_RSP_DEPTH_X + 1;
  localparam int unsigned LP_L     = C_MEM_LATENCY;

  logic [31:0]              w_offset;
  logic                     w_in_win;
  logic                     w_hpl_ok;
  logic                     w_ok;
  logic                     w_accept;
  logic                     w_pop;
  logic                     w_land;
  logic [31:0]              w_land_data;
  logic                     w_empty;

  logic [LP_CW-1:0]         r_credit;
  logic [LP_L-1:0]          r_vld;
  logic [LP_L-1:0]          r_err;
  logic [LP_CW-1:0]         r_wptr;
  logic [LP_CW-1:0]         r_rptr;
  logic [31:0]              r_fifo_data [LP_DEPTH];
  logic                     r_fifo_err  [LP_DEPTH];

  // Window decode and privilege check for the presented request
  always_comb begin
    w_offset = ireqaddr_i - C_BASE_ADDR;
    w_in_win = (ireqaddr_i >= C_BASE_ADDR) &&
               (w_offset[31:C_MEM_ADDR_W+2] == '0);
`ifdef MERLIN_IBUS_RSP_HPL_CHECK_EN
    w_hpl_ok = (ireqhpl_i >= C_MIN_HPL);
`else
    w_hpl_ok = 1'b1;
`endif
    w_ok = w_in_win & w_hpl_ok;
  end

`ifndef MERLIN_IBUS_RSP_HPL_CHECK_EN
  logic w_unused_hpl;
  assign w_unused_hpl = ^{ireqhpl_i, C_MIN_HPL};
`endif
  logic w_unused_off;
  assign w_unused_off = ^w_offset[1:0];

  // Handshakes, memory strobe and FIFO head presentation
  always_comb begin
    ireqready_o = (r_credit < LP_CW'(LP_DEPTH)) & clk_en_i;
    w_accept    = ireqvalid_i & ireqready_o;
    mem_en_o    = clk_en_i;
    mem_rd_o    = w_accept & w_ok & resetb_i;
    mem_addr_o  = w_offset[C_MEM_ADDR_W+1:2];
    w_empty     = (r_wptr == r_rptr);
    irspvalid_o = ~w_empty;
    irsprerr_o  = w_empty ? 1'b0 : r_fifo_err[r_rptr[C_RSP_DEPTH_X-1:0]];
    irspdata_o  = w_empty ? '0 : r_fifo_data[r_rptr[C_RSP_DEPTH_X-1:0]];
    w_pop       = irspvalid_o & irspready_i & clk_en_i;
    w_land      = r_vld[LP_L-1] & clk_en_i;
    w_land_data = r_err[LP_L-1] ? '0 : mem_rdata_i;
  end

  // Latency tracker: one stage per memory cycle, plus credit and pointers
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_credit <= '0;
      r_vld    <= '0;
      r_err    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else if (clk_en_i) begin
      r_vld[0] <= w_accept;
      r_err[0] <= w_accept & ~w_ok;
      for (int unsigned i = 1; i < LP_L; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
      end
      if (w_accept && !w_pop)
        r_credit <= r_credit + 1'b1;
      else if (!w_accept && w_pop)
        r_credit <= r_credit - 1'b1;
      if (w_land)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage; contents are only visible through valid pointers
  always_ff @(posedge clk_i) begin
    if (w_land) begin
      r_fifo_data[r_wptr[C_RSP_DEPTH_X-1:0]] <= w_land_data;
      r_fifo_err[r_wptr[C_RSP_DEPTH_X-1:0]]  <= r_err[LP_L-1];
    end
  end

endmodule

// File: tb/tb_merlin_ibus_rsp32.sv
// Directed self-checking bench for merlin_ibus_rsp32 (latency 1, depth 4).
module tb_merlin_ibus_rsp32;

  logic        clk_i = 1'b0;
  logic        resetb_i;
  logic        clk_en_i;
  logic        ireqready_o;
  logic        ireqvalid_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspready_i;
  logic        irspvalid_o;
  logic        irsprerr_o;
  logic [31:0] irspdata_o;
  logic        mem_en_o;
  logic        mem_rd_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_rdata_i = 32'hDEAD_BEEF;

  int total = 0;
  int bad   = 0;

  merlin_ibus_rsp32 #(
    .C_MEM_LATENCY(1),
    .C_RSP_DEPTH_X(2),
    .C_MEM_ADDR_W (12),
    .C_BASE_ADDR  (32'h0),
    .C_MIN_HPL    (2'b11)
  ) dut (
    .clk_i      (clk_i),
    .resetb_i   (resetb_i),
    .clk_en_i   (clk_en_i),
    .ireqready_o(ireqready_o),
    .ireqvalid_i(ireqvalid_i),
    .ireqhpl_i  (ireqhpl_i),
    .ireqaddr_i (ireqaddr_i),
    .irspready_i(irspready_i),
    .irspvalid_o(irspvalid_o),
    .irsprerr_o (irsprerr_o),
    .irspdata_o (irspdata_o),
    .mem_en_o   (mem_en_o),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // One-cycle memory: word at address a reads as 0xC0DE0000 | a
  always @(posedge clk_i)
    if (mem_en_o && mem_rd_o)
      mem_rdata_i <= 32'hC0DE_0000 | {20'b0, mem_addr_o};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic rr);
    ireqvalid_i = v;
    ireqaddr_i  = a;
    irspready_i = rr;
    #1;
  endtask

  task automatic expect_rsp(input string tag, input logic e, input logic [31:0] d);
    check_val({tag, "_vld"}, {31'b0, irspvalid_o}, 32'd1);
    check_val({tag, "_err"}, {31'b0, irsprerr_o}, {31'b0, e});
    check_val({tag, "_dat"}, irspdata_o, d);
  endtask

  int acc;

  initial begin
    resetb_i = 1'b0; clk_en_i = 1'b1; ireqvalid_i = 1'b0; ireqhpl_i = 2'b11;
    ireqaddr_i = '0; irspready_i = 1'b1;
    #2;
    check_val("rst_vld", {31'b0, irspvalid_o}, 32'd0);
    check_val("rst_err", {31'b0, irsprerr_o}, 32'd0);
    check_val("rst_dat", irspdata_o, 32'd0);
    check_val("rst_rdy", {31'b0, ireqready_o}, 32'd1);
    ireqvalid_i = 1'b1; #1;
    check_val("rst_rd", {31'b0, mem_rd_o}, 32'd0);
    ireqvalid_i = 1'b0; clk_en_i = 1'b0; #1;
    check_val("rst_rdy_ce0", {31'b0, ireqready_o}, 32'd0);
    clk_en_i = 1'b1;
    tick; tick;
    resetb_i = 1'b1;
    tick;

    // Single fetch at 0x10
    drive(1'b1, 32'h10, 1'b1);
    check_val("s_rd", {31'b0, mem_rd_o}, 32'd1);
    check_val("s_addr", {20'b0, mem_addr_o}, 32'd4);
    tick; drive(1'b0, 32'h0, 1'b1);
    check_val("s_t1_vld", {31'b0, irspvalid_o}, 32'd0);
    tick; #1;
    expect_rsp("s_t2", 1'b0, 32'hC0DE_0004);
    tick; #1;
    check_val("s_t3_vld", {31'b0, irspvalid_o}, 32'd0);

    // Four back-to-back fetches, responses on consecutive cycles
    for (int c = 0; c < 8; c++) begin
      drive(c < 4, 32'h10 + 32'(4 * c), 1'b1);
      if (c < 4) check_val("b2b_rdy", {31'b0, ireqready_o}, 32'd1);
      if (c >= 2 && c < 6) expect_rsp("b2b", 1'b0, 32'hC0DE_0004 + 32'(c - 2));
      else check_val("b2b_idle", {31'b0, irspvalid_o}, 32'd0);
      tick;
    end

    // Responses stalled: exactly four accepts, then drain and resume
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 32'h100 + 32'(4 * acc), 1'b0);
      check_val("stall_rdy", {31'b0, ireqready_o}, (c < 4) ? 32'd1 : 32'd0);
      if (ireqready_o) acc++;
      tick;
    end
    check_val("stall_acc", 32'(acc), 32'd4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      expect_rsp("drain", 1'b0, 32'hC0DE_0040 + 32'(k));
      tick;
    end
    drive(1'b0, 32'h0, 1'b1);
    check_val("drain_end", {31'b0, irspvalid_o}, 32'd0);
    check_val("resume_rdy", {31'b0, ireqready_o}, 32'd1);

    // Credit at depth-1 with simultaneous accept and pop keeps ready high
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h200 + 32'(4 * c), 1'b0);
      tick;
    end
    drive(1'b0, 32'h0, 1'b0);
    tick;
    drive(1'b1, 32'h20C, 1'b1);
    check_val("c3_rdy", {31'b0, ireqready_o}, 32'd1);
    expect_rsp("c3_pop", 1'b0, 32'hC0DE_0080);
    tick;
    drive(1'b0, 32'h0, 1'b0);
    check_val("c3_rdy_next", {31'b0, ireqready_o}, 32'd1);
    tick;
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      expect_rsp("c3_drain", 1'b0, 32'hC0DE_0080 + 32'(k));
      tick;
    end
    drive(1'b0, 32'h0, 1'b1);
    check_val("c3_end", {31'b0, irspvalid_o}, 32'd0);

    // Window boundaries: last word inside, first word outside
    drive(1'b1, 32'h3FFC, 1'b1);
    check_val("win_last_rd", {31'b0, mem_rd_o}, 32'd1);
    check_val("win_last_addr", {20'b0, mem_addr_o}, 32'hFFF);
    tick;
    drive(1'b1, 32'h4000, 1'b1);
    check_val("win_out_rd", {31'b0, mem_rd_o}, 32'd0);
    tick;
    drive(1'b0, 32'h0, 1'b1);
    expect_rsp("win_last", 1'b0, 32'hC0DE_0FFF);
    tick; #1;
    expect_rsp("win_out", 1'b1, 32'h0);
    tick;

    // Privilege check: hpl 0 below C_MIN_HPL=3, then hpl 3
    ireqhpl_i = 2'b00;
    drive(1'b1, 32'h20, 1'b1);
`ifdef MERLIN_IBUS_RSP_HPL_CHECK_EN
    check_val("hpl0_rd", {31'b0, mem_rd_o}, 32'd0);
`else
    check_val("hpl0_rd", {31'b0, mem_rd_o}, 32'd1);
`endif
    tick;
    ireqhpl_i = 2'b11;
    drive(1'b1, 32'h24, 1'b1);
    check_val("hpl3_rd", {31'b0, mem_rd_o}, 32'd1);
    tick;
    drive(1'b0, 32'h0, 1'b1);
`ifdef MERLIN_IBUS_RSP_HPL_CHECK_EN
    expect_rsp("hpl0", 1'b1, 32'h0);
`else
    expect_rsp("hpl0", 1'b0, 32'hC0DE_0008);
`endif
    tick; #1;
    expect_rsp("hpl3", 1'b0, 32'hC0DE_0009);
    tick;

    // Clock enable low freezes the pipeline
    drive(1'b1, 32'h30, 1'b1);
    tick;
    ireqvalid_i = 1'b0; clk_en_i = 1'b0; #1;
    check_val("ce0_rdy", {31'b0, ireqready_o}, 32'd0);
    check_val("ce0_memen", {31'b0, mem_en_o}, 32'd0);
    tick; #1;
    check_val("ce0_vld", {31'b0, irspvalid_o}, 32'd0);
    tick;
    clk_en_i = 1'b1; #1;
    check_val("ce1_vld", {31'b0, irspvalid_o}, 32'd0);
    tick; #1;
    expect_rsp("ce", 1'b0, 32'hC0DE_000C);
    tick;

    // Reset with two stored responses and one in flight
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h40 + 32'(4 * c), 1'b0);
      tick;
    end
    drive(1'b0, 32'h0, 1'b0);
    check_val("pre_rst_vld", {31'b0, irspvalid_o}, 32'd1);
    resetb_i = 1'b0; #1;
    check_val("mid_rst_vld", {31'b0, irspvalid_o}, 32'd0);
    tick;
    resetb_i = 1'b1;
    tick;
    drive(1'b0, 32'h0, 1'b1);
    check_val("post_rst_vld", {31'b0, irspvalid_o}, 32'd0);
    check_val("post_rst_rdy", {31'b0, ireqready_o}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick; #1;
      check_val("no_stale", {31'b0, irspvalid_o}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
